fifo_stream_reader: RTL and testbench

//  Read-side master for the asynchronous FIFO, in the FIFO read-clock domain.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_skid_buf.sv | 61 ++++++
 rtl/fifo_stream_reader.sv | 95 +++++++++
 tb/tb_fifo_stream_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream logic.
package fifo_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned RD_LAT     = 1;
endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry {data,last} register buffer; head entry is presented directly.
module fifo_skid_buf #(
  parameter int unsigned data_width = 8
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [data_width-1:0] din,
  input  logic                  din_last,
  input  logic                  pop,
  output logic [data_width-1:0] dout,
  output logic                  dout_last,
  output logic [1:0]            occ
);
  logic [data_width-1:0] tl_data;
  logic                  tl_last;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      dout_last <= 1'b0;
      tl_data   <= '0;
      tl_last   <= 1'b0;
      occ       <= '0;
    end else if (clear) begin
      occ <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            dout      <= din;
            dout_last <= din_last;
          end else begin
            tl_data <= din;
            tl_last <= din_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          dout      <= tl_data;
          dout_last <= tl_last;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          // Concurrent push/pop: the head always takes the oldest remaining entry.
          if (occ == 2'd1) begin
            dout      <= din;
            dout_last <= din_last;
          end else begin
            dout      <= tl_data;
            dout_last <= tl_last;
            tl_data   <= din;
            tl_last   <= din_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side master: pops with credit control, absorbs read latency, emits a valid/ready burst stream.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned data_width = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  fifo_rd,
  input  logic [data_width-1:0] fifo_rdata,
  input  logic                  fifo_valid,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [7:0]            err_cnt
);
  localparam int unsigned      IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  state_t           state, next_state;
  logic [1:0]       occ;
  logic             infl, drop, drop_nxt;
  logic [IDX_W-1:0] burst_idx;
  logic             pop, capture, unexpected, tag_last;
  logic [2:0]       credit;

  assign pop      = out_valid & out_ready;
  assign out_valid = (occ != 2'd0);
  assign credit   = 3'(occ) + 3'(infl) - 3'(pop);
  assign fifo_rd  = rst_n & enable & ~flush & ~fifo_empty & (credit < 3'(SKID_DEPTH));
  assign tag_last = (burst_idx == LAST_IDX);

  // A read in flight during flush returns in the flush cycle itself and is discarded
  // there; drop only stays armed if that return has not yet been seen.
  assign capture    = fifo_valid & infl & ~drop & ~flush;
  assign unexpected = fifo_valid & ~infl & ~drop;
  assign drop_nxt   = drop ? ~fifo_valid : (flush & infl & ~fifo_valid);

  fifo_skid_buf #(.data_width(data_width)) u_skid (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (capture),
    .din       (fifo_rdata),
    .din_last  (tag_last),
    .pop       (pop),
    .dout      (out_data),
    .dout_last (out_last),
    .occ       (occ)
  );

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      infl      <= 1'b0;
      drop      <= 1'b0;
      burst_idx <= '0;
      beat_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      state <= next_state;
      infl  <= fifo_rd;
      drop  <= drop_nxt;
      if (flush)        burst_idx <= '0;
      else if (capture) burst_idx <= tag_last ? '0 : burst_idx + IDX_W'(1);
      if (pop) beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      if ((fifo_underflow | unexpected) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (fifo_rd || occ != 2'd0 || infl) next_state = ACTIVE;
      ACTIVE: begin
        if (occ == 2'd2 && !out_ready)                      next_state = STALL;
        else if (occ == 2'd0 && !infl && !fifo_rd && !drop) next_state = IDLE;
      end
      STALL:  if (out_ready) next_state = ACTIVE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = drop_nxt ? ACTIVE : IDLE;
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a 1-cycle-latency FIFO model.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic        rd_clk = 1'b0;
  logic        rst_n, enable, flush, out_ready, fifo_underflow;
  logic        fifo_rd, fifo_valid, fifo_empty, out_valid, out_last, busy;
  logic [7:0]  fifo_rdata, out_data, err_cnt;
  logic [15:0] beat_cnt;

  logic [7:0]  fmem [256];
  logic [7:0]  head = '0;
  logic [7:0]  tail = '0;
  logic        mvalid = 1'b0;
  logic [7:0]  mdata = '0;
  logic        inj_valid = 1'b0;
  logic [7:0]  inj_data = '0;
  logic [8:0]  got [$];
  int unsigned nrd = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n0, g0;

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (head == tail);
  assign fifo_valid = mvalid | inj_valid;
  assign fifo_rdata = inj_valid ? inj_data : mdata;

  always @(posedge rd_clk) begin
    mvalid <= 1'b0;
    if (fifo_rd && !fifo_empty) begin
      mdata  <= fmem[head];
      head   <= head + 8'd1;
      mvalid <= 1'b1;
    end
  end

  always @(posedge rd_clk) begin
    if (rst_n && out_valid && out_ready) got.push_back({out_last, out_data});
    if (fifo_rd) nrd <= nrd + 1;
  end

  fifo_stream_reader #(.data_width(8), .BURST_LEN(4), .CNT_WIDTH(16)) dut (
    .rd_clk         (rd_clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .flush          (flush),
    .fifo_rd        (fifo_rd),
    .fifo_rdata     (fifo_rdata),
    .fifo_valid     (fifo_valid),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .busy           (busy),
    .beat_cnt       (beat_cnt),
    .err_cnt        (err_cnt)
  );

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[tail] = base + 8'(i);
      tail = tail + 8'd1;
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((busy || out_valid) && k < 200) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(k < 200), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; out_ready = 1'b1; fifo_underflow = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_beat_cnt",  32'(beat_cnt),  32'd0);
    chk("rst_err_cnt",   32'(err_cnt),   32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: streaming at full rate
    n0 = nrd;
    load(8'h10, 8);
    enable = 1'b1;
    #1;
    chk("t1_first_rd", 32'(fifo_rd), 32'd1);
    tick();
    chk("t1_lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_data",  32'(out_data),  32'h10 + 32'(i));
      chk("t1_last",  32'(out_last),  32'((i % 4) == 3));
      tick();
    end
    chk("t1_end_valid", 32'(out_valid), 32'd0);
    chk("t1_beat_cnt",  32'(beat_cnt),  32'd8);
    chk("t1_nrd",       nrd - n0,       32'd8);
    drain();

    // Test 2: downstream stall
    out_ready = 1'b0;
    n0 = nrd;
    load(8'h10, 8);
    repeat (10) tick();
    chk("t2_pops_stalled", nrd - n0,          32'd2);
    chk("t2_state",        32'(dut.state),    32'(STALL));
    chk("t2_occ",          32'(dut.occ),      32'd2);
    chk("t2_head",         32'(out_data),     32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_valid("t2_wait");
      chk("t2_data", 32'(out_data), 32'h10 + 32'(i));
      chk("t2_last", 32'(out_last), 32'((i % 4) == 3));
      tick();
    end
    drain();
    chk("t2_beat_cnt", 32'(beat_cnt), 32'd16);

    // Test 3: flush with a read in flight and one word buffered
    out_ready = 1'b0;
    g0 = got.size();
    load(8'h20, 3);
    tick();
    tick();
    chk("t3_pre_occ",  32'(dut.occ),  32'd1);
    chk("t3_pre_infl", 32'(dut.infl), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_valid_after_flush", 32'(out_valid),      32'd0);
    chk("t3_burst_idx",         32'(dut.burst_idx),  32'd0);
    out_ready = 1'b1;
    wait_valid("t3_wait");
    chk("t3_next_data", 32'(out_data), 32'h22);
    chk("t3_next_last", 32'(out_last), 32'd0);
    tick();
    drain();
    chk("t3_delivered", got.size() - g0, 32'd1);
    chk("t3_err_cnt",   32'(err_cnt),    32'd0);

    // Test 4: error counting and saturation
    g0 = got.size();
    inj_data = 8'h55;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    repeat (3) begin
      fifo_underflow = 1'b1;
      tick();
      fifo_underflow = 1'b0;
      tick();
    end
    chk("t4_err_cnt",   32'(err_cnt),     32'd4);
    chk("t4_no_output", got.size() - g0,  32'd0);
    chk("t4_out_valid", 32'(out_valid),   32'd0);
    inj_valid = 1'b1;
    fifo_underflow = 1'b1;
    tick();
    inj_valid = 1'b0;
    fifo_underflow = 1'b0;
    tick();
    chk("t4_err_both", 32'(err_cnt), 32'd5);
    fifo_underflow = 1'b1;
    repeat (300) tick();
    fifo_underflow = 1'b0;
    tick();
    chk("t4_err_sat", 32'(err_cnt), 32'd255);

    // Test 5: enable dropped mid-burst, burst index resumes
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_idx_zero", 32'(dut.burst_idx), 32'd0);
    enable = 1'b0;
    g0 = got.size();
    n0 = nrd;
    load(8'h30, 4);
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    repeat (6) tick();
    chk("t5_rd_while_off",  nrd - n0,        32'd2);
    chk("t5_inflight_done", got.size() - g0, 32'd2);
    enable = 1'b1;
    tick();
    drain();
    chk("t5_total", got.size() - g0, 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t5_beat", 32'(got[g0 + i]), {23'd0, (i == 3), 8'h30 + 8'(i)});

    // Test 6: asynchronous reset mid-transfer
    out_ready = 1'b0;
    load(8'h40, 3);
    repeat (5) tick();
    chk("t6_pre_occ", 32'(dut.occ), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_data",  32'(out_data),  32'd0);
    chk("t6_out_last",  32'(out_last),  32'd0);
    chk("t6_busy",      32'(busy),      32'd0);
    chk("t6_fifo_rd",   32'(fifo_rd),   32'd0);
    chk("t6_beat_cnt",  32'(beat_cnt),  32'd0);
    chk("t6_err_cnt",   32'(err_cnt),   32'd0);
    tick();
    enable = 1'b0;
    rst_n = 1'b1;
    tick();
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    tick();
    chk("t6_err_after", 32'(err_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
